seq_shift_unit: RTL and testbench

//  Multi-cycle shifter for the EX stage. It takes the same operation encoding as the combinational

---
 rtl/seq_shift_unit.sv | 162 ++++++++++++++++
 tb/tb_seq_shift_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module      : seq_shift_unit
//  Description : Multi-cycle shifter. One power-of-two barrel stage is applied
//                per clock (stage k shifts by 2^k when shamt bit k is set).
//                It uses a start/done handshake, and result holds its value
//                until the next completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_shift_unit #(
    parameter int WIDTH      = 32,
    parameter int SHAMT_W    = 5,
    parameter int EARLY_EXIT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               right,
    input  logic               arith,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    localparam int c_STAGE_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [WIDTH-1:0]     r_work;
    logic [WIDTH-1:0]     r_result;
    logic [SHAMT_W-1:0]   r_shamt;
    logic                 r_right;
    logic                 r_arith;
    logic                 r_sign;
    logic [c_STAGE_W-1:0] r_stage;

    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH-1:0]     w_fill;
    logic [WIDTH-1:0]     w_step;
    logic [WIDTH-1:0]     w_cand [SHAMT_W];

    // Right shifts fill with the latched sign only for arithmetic mode;
    // left arithmetic behaves exactly like left logical.
    assign w_fill = {WIDTH{r_arith & r_sign}};

    // One candidate per stage: the working value shifted by the stage's
    // fixed 2^k amount, or passed through when that shamt bit is clear.
    generate
        for (genvar j = 0; j < SHAMT_W; j++) begin : g_stage
            localparam int c_AMT = 1 << j;
            logic [WIDTH-1:0] w_shl;
            logic [WIDTH-1:0] w_shr;
            assign w_shl     = {r_work[WIDTH-1-c_AMT:0], {c_AMT{1'b0}}};
            assign w_shr     = {w_fill[c_AMT-1:0], r_work[WIDTH-1:c_AMT]};
            assign w_cand[j] = r_shamt[j] ? (r_right ? w_shr : w_shl) : r_work;
        end
    endgenerate

    // Select the candidate belonging to the current stage.
    always_comb begin
        w_step = r_work;
        for (int j = 0; j < SHAMT_W; j++) begin
            if (int'(r_stage) == j) begin
                w_step = w_cand[j];
            end
        end
    end

    // This is the final stage when the counter reaches the top, or (with
    // early exit) when no higher shamt bits remain to be applied.
    always_comb begin
        w_last = (int'(r_stage) == SHAMT_W - 1);
        if ((EARLY_EXIT != 0) && ((r_shamt >> (int'(r_stage) + 1)) == '0)) begin
            w_last = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs; start is only honoured in IDLE/DONE.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_SHIFT;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Datapath: latch operands on accept, step once per SHIFT cycle, and
    // publish the result on the final stage so it stays put while the next
    // operation is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_work   <= '0;
            r_result <= '0;
            r_shamt  <= '0;
            r_right  <= 1'b0;
            r_arith  <= 1'b0;
            r_sign   <= 1'b0;
            r_stage  <= '0;
        end else if (w_accept) begin
            r_work  <= a;
            r_shamt <= shamt;
            r_right <= right;
            r_arith <= arith;
            r_sign  <= a[WIDTH-1];
            r_stage <= '0;
        end else if (busy) begin
            if (w_last) begin
                r_result <= w_step;
            end else begin
                r_work  <= w_step;
                r_stage <= r_stage + c_STAGE_W'(1);
            end
        end
    end

    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_seq_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_shift_unit
//  Description : Self-checking bench for seq_shift_unit: directed vector
//                table, handshake and reset sequences, and an operand sweep
//                checked against the language shift operators.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_shift_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        right;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks;
    int n_errors;

    seq_shift_unit #(
        .WIDTH      (32),
        .SHAMT_W    (5),
        .EARLY_EXIT (1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .shamt  (shamt),
        .right  (right),
        .arith  (arith),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  shamt;
        logic        right;
        logic        arith;
        logic [31:0] exp_result;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_result(input logic [31:0] x, input logic [4:0] s,
                                                 input logic r, input logic ar);
        logic [31:0] y;
        if (r) y = ar ? $unsigned($signed(x) >>> s) : (x >> s);
        else   y = ar ? (x <<< s) : (x << s);
        return y;
    endfunction

    function automatic int model_lat(input logic [4:0] s);
        int l;
        l = 1;
        for (int b = 0; b < 5; b++) begin
            if (s[b]) l = b + 1;
        end
        return l;
    endfunction

    // Launch one operation and wait (bounded) for done. lat counts edges
    // after the accepting edge; -1 means done never arrived.
    task automatic run_op(input logic [31:0] ta, input logic [4:0] ts, input logic tr,
                          input logic tar, output logic [31:0] res, output int lat);
        @(negedge clk);
        a = ta; shamt = ts; right = tr; arith = tar; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // scramble inputs: only latched copies may matter
        a = $urandom; shamt = 5'($urandom); right = 1'($urandom); arith = 1'($urandom);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done && lat < 40);
        if (!done) lat = -1;
        res = result;
    endtask

    vec_t        vecs [10];
    logic [31:0] res;
    int          lat;
    int          ndone;
    logic [31:0] op;
    logic [31:0] specials [3];

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1; start = 1'b0; a = '0; shamt = '0; right = 1'b0; arith = 1'b0;

        vecs[0] = '{32'hFFFFFF38, 5'd3,  1'b1, 1'b1, 32'hFFFFFFE7, 2};
        vecs[1] = '{32'h08FF76F8, 5'd18, 1'b0, 1'b0, 32'hDBE00000, 5};
        vecs[2] = '{32'h08FF76F8, 5'd18, 1'b1, 1'b1, 32'h0000023F, 5};
        vecs[3] = '{32'hFFFFFF38, 5'd4,  1'b1, 1'b0, 32'h0FFFFFF3, 3};
        vecs[4] = '{32'hFFFFFF38, 5'd0,  1'b1, 1'b0, 32'hFFFFFF38, 1};
        vecs[5] = '{32'h80000000, 5'd31, 1'b1, 1'b1, 32'hFFFFFFFF, 5};
        vecs[6] = '{32'h80000000, 5'd31, 1'b1, 1'b0, 32'h00000001, 5};
        vecs[7] = '{32'h7FFFFFFF, 5'd31, 1'b1, 1'b1, 32'h00000000, 5};
        vecs[8] = '{32'h00000001, 5'd1,  1'b0, 1'b1, 32'h00000002, 1};
        vecs[9] = '{32'h12345678, 5'd8,  1'b0, 1'b0, 32'h34567800, 4};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // directed table
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].shamt, vecs[i].right, vecs[i].arith, res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp_result);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
        end

        // start held high during a whole op: only one accept, single done
        @(negedge clk);
        a = 32'h12345679; shamt = 5'd31; right = 1'b0; arith = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        ndone = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (done) begin
                ndone++;
                start = 1'b0;
            end
        end while (!done && lat < 40);
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("hold_latency", 32'(lat), 32'd5);
        check("hold_result", result, 32'h80000000);
        check("hold_done_pulses", 32'(ndone), 32'd1);
        check("hold_idle_busy", {31'd0, busy}, 32'd0);

        // back-to-back: start on the done cycle
        run_op(32'hFFFFFF38, 5'd3, 1'b1, 1'b1, res, lat);
        check("b2b_first_result", res, 32'hFFFFFFE7);
        a = 32'h08FF76F8; shamt = 5'd18; right = 1'b0; arith = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_done_drop", {31'd0, done}, 32'd0);
        check("b2b_result_held", result, 32'hFFFFFFE7);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done && lat < 40);
        check("b2b_second_latency", 32'(lat), 32'd5);
        check("b2b_second_result", result, 32'hDBE00000);

        // reset mid-SHIFT, with a start in the last reset cycle
        @(negedge clk);
        a = 32'h0000FFFF; shamt = 5'd31; right = 1'b0; arith = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy_before", {31'd0, busy}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        check("midrst_idle_busy", {31'd0, busy}, 32'd0);
        check("midrst_idle_done", {31'd0, done}, 32'd0);

        // sweep: specials over every shamt and mode, then random operands
        specials[0] = 32'hFFFFFF38;
        specials[1] = 32'h80000000;
        specials[2] = 32'h7FFFFFFF;
        for (int k = 0; k < 3; k++) begin
            for (int s = 0; s < 32; s++) begin
                for (int m = 0; m < 4; m++) begin
                    run_op(specials[k], 5'(s), m[1], m[0], res, lat);
                    check($sformatf("sweep_sp%0d_s%0d_m%0d", k, s, m), res,
                          model_result(specials[k], 5'(s), m[1], m[0]));
                    check($sformatf("sweep_sp%0d_s%0d_m%0d_lat", k, s, m), 32'(lat),
                          32'(model_lat(5'(s))));
                end
            end
        end
        for (int i = 0; i < 300; i++) begin
            op = (i < 3) ? specials[i] : $urandom;
            for (int m = 0; m < 4; m++) begin
                run_op(op, 5'(i % 32), m[1], m[0], res, lat);
                check($sformatf("sweep_rnd%0d_m%0d", i, m), res,
                      model_result(op, 5'(i % 32), m[1], m[0]));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
